// File: rtl/tft43_gram_reader.sv
// 8080-style read-path master for the 4.3'' TFT panel: command write, bus turnaround, N read strobes.
// Optional macro TFT43_RD_DUMMY_EN inserts one discarded read strobe after the turnaround.
module tft43_gram_reader #(
    parameter int unsigned WR_LOW  = 2,
    parameter int unsigned WR_HIGH = 2,
    parameter int unsigned RD_LOW  = 4,
    parameter int unsigned RD_HIGH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic        iStart,
    input  logic [15:0] iCmd,
    input  logic [19:0] iCount,
    input  logic        iReady,
    output logic [15:0] oData,
    output logic        oValid,
    output logic        oBusy,
    output logic        oDone,
    output logic        LCD_CS,
    output logic        LCD_RS,
    output logic        LCD_WR,
    output logic        LCD_RD,
    output logic [15:0] LCD_DATA_O,
    output logic        LCD_DATA_OE,
    input  logic [15:0] LCD_DATA_I
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD_LO,
        S_CMD_HI,
        S_TURN,
        S_RD_LO,
        S_RD_HI,
        S_WAIT_RDY,
        S_FINISH
    } state_t;

    localparam logic [15:0] WL_LAST = 16'(WR_LOW - 1);
    localparam logic [15:0] WH_LAST = 16'(WR_HIGH - 1);
    localparam logic [15:0] RL_LAST = 16'(RD_LOW - 1);
    localparam logic [15:0] RH_LAST = 16'(RD_HIGH - 1);

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [19:0] rem_q, rem_d;
    logic [15:0] cmd_q, cmd_d;
    logic [15:0] data_q, data_d;
    logic        valid_q, valid_d;
    logic        dummy_q, dummy_d;
    logic        accept;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            cmd_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            dummy_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            cmd_q   <= cmd_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            dummy_q <= dummy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 16'd1;
        rem_d   = rem_q;
        cmd_d   = cmd_q;
        data_d  = data_q;
        valid_d = valid_q;
        dummy_d = dummy_q;
        accept  = valid_q & iReady;

        // rem_d already reflects this cycle's acceptance when the branch decisions below read it
        if (accept) begin
            valid_d = 1'b0;
            if (rem_q != '0) rem_d = rem_q - 20'd1;
        end

        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (en && iStart) begin
                    cmd_d   = iCmd;
                    rem_d   = iCount;
                    state_d = S_CMD_LO;
                end
            end
            S_CMD_LO: begin
                if (cnt_q == WL_LAST) begin
                    cnt_d   = '0;
                    state_d = S_CMD_HI;
                end
            end
            S_CMD_HI: begin
                if (cnt_q == WH_LAST) begin
                    cnt_d   = '0;
                    state_d = S_TURN;
                end
            end
            S_TURN: begin
                cnt_d = '0;
                if (rem_q == '0) begin
                    state_d = S_FINISH;
                end else begin
                    state_d = S_RD_LO;
`ifdef TFT43_RD_DUMMY_EN
                    dummy_d = 1'b1;
`else
                    dummy_d = 1'b0;
`endif
                end
            end
            S_RD_LO: begin
                if (cnt_q == RL_LAST) begin
                    cnt_d   = '0;
                    state_d = S_RD_HI;
                    dummy_d = 1'b0;
                    if (!dummy_q) begin
                        data_d  = LCD_DATA_I;
                        valid_d = 1'b1;
                    end
                end
            end
            S_RD_HI: begin
                if (cnt_q == RH_LAST) begin
                    cnt_d = '0;
                    if (valid_q && !iReady) state_d = S_WAIT_RDY;
                    else if (rem_d == '0)   state_d = S_FINISH;
                    else                    state_d = S_RD_LO;
                end
            end
            S_WAIT_RDY: begin
                cnt_d = '0;
                if (accept) state_d = (rem_d == '0) ? S_FINISH : S_RD_LO;
            end
            S_FINISH: begin
                cnt_d   = '0;
                state_d = S_IDLE;
            end
            default: begin
                cnt_d   = '0;
                state_d = S_IDLE;
            end
        endcase

        // Abort: oData keeps its last value, everything else returns to idle
        if (!en && state_q != S_IDLE) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            valid_d = 1'b0;
            dummy_d = 1'b0;
        end
    end

    always_comb begin
        LCD_CS      = 1'b1;
        LCD_RS      = 1'b1;
        LCD_WR      = 1'b1;
        LCD_RD      = 1'b1;
        LCD_DATA_OE = 1'b0;
        LCD_DATA_O  = '0;
        oBusy       = 1'b0;
        oDone       = 1'b0;
        case (state_q)
            S_CMD_LO: begin
                LCD_CS      = 1'b0;
                LCD_RS      = 1'b0;
                LCD_WR      = 1'b0;
                LCD_DATA_OE = 1'b1;
                LCD_DATA_O  = cmd_q;
                oBusy       = 1'b1;
            end
            S_CMD_HI: begin
                LCD_CS      = 1'b0;
                LCD_RS      = 1'b0;
                LCD_DATA_OE = 1'b1;
                LCD_DATA_O  = cmd_q;
                oBusy       = 1'b1;
            end
            S_TURN, S_RD_HI, S_WAIT_RDY: begin
                LCD_CS = 1'b0;
                oBusy  = 1'b1;
            end
            S_RD_LO: begin
                LCD_CS = 1'b0;
                LCD_RD = 1'b0;
                oBusy  = 1'b1;
            end
            S_FINISH: oDone = 1'b1;
            default: ;
        endcase
    end

    assign oData  = data_q;
    assign oValid = valid_q;

endmodule

// File: tb/tb_tft43_gram_reader.sv
// Randomized bench for tft43_gram_reader: a bus model feeds words per RD strobe and a
// timing/scoreboard model derived from the phase lengths checks every transfer.
module tb_tft43_gram_reader;

    localparam int WRL = 2;
    localparam int WRH = 2;
    localparam int RDL = 4;
    localparam int RDH = 4;
`ifdef TFT43_RD_DUMMY_EN
    localparam int DUMMY = 1;
`else
    localparam int DUMMY = 0;
`endif

    logic        clk;
    logic        rst_n;
    logic        en;
    logic        iStart;
    logic [15:0] iCmd;
    logic [19:0] iCount;
    logic        iReady;
    logic [15:0] oData;
    logic        oValid;
    logic        oBusy;
    logic        oDone;
    logic        LCD_CS;
    logic        LCD_RS;
    logic        LCD_WR;
    logic        LCD_RD;
    logic [15:0] LCD_DATA_O;
    logic        LCD_DATA_OE;
    logic [15:0] LCD_DATA_I;

    int n_cmp = 0;
    int n_err = 0;
    logic [15:0] bus_vals[$];
    logic [15:0] exp_q[$];

    tft43_gram_reader #(
        .WR_LOW (WRL),
        .WR_HIGH(WRH),
        .RD_LOW (RDL),
        .RD_HIGH(RDH)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .iStart     (iStart),
        .iCmd       (iCmd),
        .iCount     (iCount),
        .iReady     (iReady),
        .oData      (oData),
        .oValid     (oValid),
        .oBusy      (oBusy),
        .oDone      (oDone),
        .LCD_CS     (LCD_CS),
        .LCD_RS     (LCD_RS),
        .LCD_WR     (LCD_WR),
        .LCD_RD     (LCD_RD),
        .LCD_DATA_O (LCD_DATA_O),
        .LCD_DATA_OE(LCD_DATA_OE),
        .LCD_DATA_I (LCD_DATA_I)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, ".cs"},    LCD_CS, 1);
        check({tag, ".rs"},    LCD_RS, 1);
        check({tag, ".wr"},    LCD_WR, 1);
        check({tag, ".rd"},    LCD_RD, 1);
        check({tag, ".oe"},    LCD_DATA_OE, 0);
        check({tag, ".do"},    LCD_DATA_O, 0);
        check({tag, ".valid"}, oValid, 0);
        check({tag, ".busy"},  oBusy, 0);
        check({tag, ".done"},  oDone, 0);
    endtask

    // kill_at > 0: at that cycle either drop en (kill_rst=0) or pulse rst_n (kill_rst=1)
    task automatic run(input logic [15:0] cmd, input int cnt, input int rdy_pct,
                       input int hold, input int kill_at, input bit kill_rst);
        int  falls = 0, wr_lo = 0, words = 0, first_v = -1, last_v = 0, done_cyc = 0;
        int  strobes;
        bit  prev_rd = 1'b1, prev_v = 1'b0, done = 1'b0;
        logic [15:0] v;
        strobes = cnt + ((cnt > 0) ? DUMMY : 0);
        exp_q.delete();
        @(negedge clk);
        en = 1'b1; iCmd = cmd; iCount = 20'(cnt); iStart = 1'b1; iReady = 1'b0;
        @(posedge clk);
        for (int cyc = 1; cyc <= 2000 && !done; cyc++) begin
            @(negedge clk);
            iStart = 1'($urandom_range(1));
            iCmd   = 16'($urandom);
            iCount = 20'($urandom);
            if (cyc == kill_at) begin
                iStart = 1'b0;
                if (kill_rst) begin
                    rst_n = 1'b0;
                    #1;
                    check_idle("rst_mid");
                    check("rst_mid.odata", oData, 0);
                    @(negedge clk);
                    rst_n = 1'b1;
                end else begin
                    en = 1'b0;
                    @(negedge clk);
                    check_idle("abort");
                    en = 1'b1;
                end
                return;
            end
            if (cyc == 1) check("busy", oBusy, 1);
            check("data_o", LCD_DATA_O, LCD_DATA_OE ? cmd : 16'h0);
            if (!LCD_WR) wr_lo++;
            if (!LCD_RD && prev_rd) begin
                check("rd_fall_pending", oValid, 0);
                v = (bus_vals.size() > 0) ? bus_vals.pop_front() : 16'($urandom);
                LCD_DATA_I = v;
                if (!(DUMMY == 1 && falls == 0)) exp_q.push_back(v);
                falls++;
            end
            prev_rd = LCD_RD;
            if (oValid && !prev_v) begin
                if (first_v < 0) begin
                    first_v = cyc;
                    check("first_valid", cyc, 1 + WRL + WRH + 1 + RDL + DUMMY * (RDL + RDH));
                end else if (rdy_pct == 100 && hold == 0) begin
                    check("period", cyc - last_v, RDL + RDH);
                end
                last_v = cyc;
            end
            prev_v = oValid;
            if (hold > 0) iReady = (first_v >= 0 && cyc >= first_v + hold);
            else          iReady = ($urandom_range(99) < rdy_pct);
            if (hold > 0 && oValid && !iReady && exp_q.size() > 0) begin
                check("hold_data", oData, exp_q[0]);
                check("hold_rd", LCD_RD, 1);
            end
            if (oValid && iReady) begin
                if (exp_q.size() == 0) check("extra_word", 1, 0);
                else                   check("word", oData, exp_q.pop_front());
                words++;
            end
            if (oDone) begin
                done = 1'b1;
                done_cyc = cyc;
                iStart = 1'b0;
                iReady = 1'b0;
            end
        end
        if (!done) begin
            check("timeout", 0, 1);
            return;
        end
        check("words", words, cnt);
        check("rd_strobes", falls, strobes);
        check("wr_low", wr_lo, WRL);
        if (rdy_pct == 100 && hold == 0)
            check("done_cyc", done_cyc, 1 + WRL + WRH + 1 + (RDL + RDH) * strobes);
        @(negedge clk);
        check("post.busy", oBusy, 0);
        check("post.cs", LCD_CS, 1);
        check("post.done", oDone, 0);
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; iStart = 1'b0; iCmd = '0; iCount = '0;
        iReady = 1'b0; LCD_DATA_I = '0;
        repeat (2) @(negedge clk);
        check_idle("reset");
        check("reset.odata", oData, 0);
        rst_n = 1'b1;

        bus_vals = '{16'hF800, 16'h07E0, 16'h001F};
        run(16'h2E00, 3, 100, 0, 0, 1'b0);
        run(16'h0A00, 0, 100, 0, 0, 1'b0);
        run(16'($urandom), 2, 100, 20, 0, 1'b0);
        run(16'($urandom), 5, 100, 0, 15, 1'b0);
        run(16'($urandom), 1, 100, 0, 0, 1'b0);
        run(16'($urandom), 4, 100, 0, 12, 1'b1);
        run(16'($urandom), 2, 100, 0, 0, 1'b0);
        bus_vals = '{16'hDEAD, 16'h1234};
        run(16'h2E00, 1, 100, 0, 0, 1'b0);
        for (int t = 0; t < 8; t++)
            run(16'($urandom), int'($urandom_range(4)), int'($urandom_range(100, 30)), 0, 0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
